hsv_to_rgb: RTL and testbench

- Pipelined converter from HSV (H 0-360 degrees, S 0-255, V 0-255) back to 8-bit RGB. It is the inverse of the vision subsystem's RGB-to-HSV stage.
- Used to regenerate display or overlay colours from hue-domain thresholds and annotations, and for round-trip checks of the colour-threshold path.
- Streams one pixel per clock with a valid strobe. There is no backpressure.

---
 rtl/hsv_pkg.sv | 41 ++++
 rtl/hsv_hue_sector.sv | 35 +++
 rtl/hsv_to_rgb.sv | 154 +++++++++++++++
 tb/tb_hsv_to_rgb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared constants and types for the HSV-to-RGB converter.
//   H_W       hue width (0-360 nominal, up to 511 accepted)
//   C_W       saturation / value / RGB channel width
//   HUE_FULL  one full turn of hue, in degrees
//   SECTOR_W  width of one hue sector, in degrees
//   FRAC_MUL  scale that maps 0..59 onto 0..251 after a >>8
package hsv_pkg;

  localparam int H_W      = 9;
  localparam int C_W      = 8;
  localparam int HUE_FULL = 360;
  localparam int SECTOR_W = 60;
  localparam int FRAC_MUL = 1092;

  typedef enum logic [2:0] {
    SEC_0 = 3'd0,  // red -> yellow
    SEC_1 = 3'd1,  // yellow -> green
    SEC_2 = 3'd2,  // green -> cyan
    SEC_3 = 3'd3,  // cyan -> blue
    SEC_4 = 3'd4,  // blue -> magenta
    SEC_5 = 3'd5   // magenta -> red
  } sector_t;

  // Start angle of a sector. This is the value subtracted from the reduced
  // hue to give the in-sector offset.
  function automatic logic [H_W-1:0] sector_base(input sector_t sec);
    logic [H_W-1:0] base;
    base = '0;
    case (sec)
      SEC_0:   base = H_W'(0);
      SEC_1:   base = H_W'(SECTOR_W);
      SEC_2:   base = H_W'(2 * SECTOR_W);
      SEC_3:   base = H_W'(3 * SECTOR_W);
      SEC_4:   base = H_W'(4 * SECTOR_W);
      SEC_5:   base = H_W'(5 * SECTOR_W);
      default: base = '0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/hsv_hue_sector.sv
// Combinational hue reduction for the first pipeline stage.
//   hue    raw hue, 0..511 (values 360 and above wrap once)
//   sector hue sector 0..5
//   frac8  position inside the sector, scaled to 0..251
import hsv_pkg::*;

module hsv_hue_sector (
  input  logic [H_W-1:0] hue,
  output sector_t        sector,
  output logic [C_W-1:0] frac8
);

  logic [H_W-1:0] h_red;
  logic [H_W-1:0] f_deg;

  // A single wrap is enough because the input never exceeds 511 < 720.
  assign h_red = (hue >= H_W'(HUE_FULL)) ? hue - H_W'(HUE_FULL) : hue;

  // Comparator chain in place of a divide by 60.
  always_comb begin
    sector = SEC_0;
    if      (h_red >= H_W'(5 * SECTOR_W)) sector = SEC_5;
    else if (h_red >= H_W'(4 * SECTOR_W)) sector = SEC_4;
    else if (h_red >= H_W'(3 * SECTOR_W)) sector = SEC_3;
    else if (h_red >= H_W'(2 * SECTOR_W)) sector = SEC_2;
    else if (h_red >= H_W'(SECTOR_W))     sector = SEC_1;
    else                                  sector = SEC_0;
  end

  assign f_deg = h_red - sector_base(sector);

  // f_deg is at most 59, so 59*1092 = 64428 still fits in 16 bits.
  assign frac8 = C_W'((17'(f_deg) * 17'(FRAC_MUL)) >> 8);

endmodule

// File: rtl/hsv_to_rgb.sv
// Four-stage pipelined HSV to 8-bit RGB converter, one pixel per clock.
//   clk        system clock
//   rst        synchronous active-high reset, clears every pipeline register
//   hsv_h      hue 0..511 (0..360 nominal)
//   hsv_s      saturation
//   hsv_v      value
//   valid_in   input pixel qualifier
//   rgb_r/g/b  converted pixel, held between valid pixels
//   valid_out  one-cycle strobe, 4 cycles after the matching valid_in
import hsv_pkg::*;

module hsv_to_rgb (
  input  logic           clk,
  input  logic           rst,
  input  logic [H_W-1:0] hsv_h,
  input  logic [C_W-1:0] hsv_s,
  input  logic [C_W-1:0] hsv_v,
  input  logic           valid_in,
  output logic [C_W-1:0] rgb_r,
  output logic [C_W-1:0] rgb_g,
  output logic [C_W-1:0] rgb_b,
  output logic           valid_out
);

  // Stage 1: reduced hue
  sector_t        sec_c;
  logic [C_W-1:0] frac_c;

  sector_t        s1_sector;
  logic [C_W-1:0] s1_frac;
  logic [C_W-1:0] s1_s;
  logic [C_W-1:0] s1_v;
  logic           s1_valid;

  // Stage 2: chroma-like term x = V*S/256
  sector_t        s2_sector;
  logic [C_W-1:0] s2_frac;
  logic [C_W-1:0] s2_x;
  logic [C_W-1:0] s2_v;
  logic           s2_valid;

  // Stage 3: the three derived channel levels
  sector_t        s3_sector;
  logic [C_W-1:0] s3_p;
  logic [C_W-1:0] s3_q;
  logic [C_W-1:0] s3_t;
  logic [C_W-1:0] s3_v;
  logic           s3_valid;

  logic [C_W-1:0] x_c;
  logic [C_W-1:0] p_c;
  logic [C_W-1:0] q_c;
  logic [C_W-1:0] t_c;
  logic [C_W-1:0] r_c;
  logic [C_W-1:0] g_c;
  logic [C_W-1:0] b_c;

  hsv_hue_sector u_hue_sector (
    .hue    (hsv_h),
    .sector (sec_c),
    .frac8  (frac_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sector <= SEC_0;
      s1_frac   <= '0;
      s1_s      <= '0;
      s1_v      <= '0;
      s1_valid  <= 1'b0;
    end else begin
      s1_sector <= sec_c;
      s1_frac   <= frac_c;
      s1_s      <= hsv_s;
      s1_v      <= hsv_v;
      s1_valid  <= valid_in;
    end
  end

  assign x_c = C_W'((16'(s1_v) * 16'(s1_s)) >> 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sector <= SEC_0;
      s2_frac   <= '0;
      s2_x      <= '0;
      s2_v      <= '0;
      s2_valid  <= 1'b0;
    end else begin
      s2_sector <= s1_sector;
      s2_frac   <= s1_frac;
      s2_x      <= x_c;
      s2_v      <= s1_v;
      s2_valid  <= s1_valid;
    end
  end

  // x <= V by construction, and the scaled products are at most x, so the
  // subtractions below cannot wrap.
  assign p_c = s2_v - s2_x;
  assign q_c = s2_v - C_W'((16'(s2_x) * 16'(s2_frac)) >> 8);
  assign t_c = s2_v - C_W'((17'(s2_x) * (17'd256 - 17'(s2_frac))) >> 8);

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_sector <= SEC_0;
      s3_p      <= '0;
      s3_q      <= '0;
      s3_t      <= '0;
      s3_v      <= '0;
      s3_valid  <= 1'b0;
    end else begin
      s3_sector <= s2_sector;
      s3_p      <= p_c;
      s3_q      <= q_c;
      s3_t      <= t_c;
      s3_v      <= s2_v;
      s3_valid  <= s2_valid;
    end
  end

  always_comb begin
    r_c = s3_v;
    g_c = s3_t;
    b_c = s3_p;
    case (s3_sector)
      SEC_0: begin r_c = s3_v; g_c = s3_t; b_c = s3_p; end
      SEC_1: begin r_c = s3_q; g_c = s3_v; b_c = s3_p; end
      SEC_2: begin r_c = s3_p; g_c = s3_v; b_c = s3_t; end
      SEC_3: begin r_c = s3_p; g_c = s3_q; b_c = s3_v; end
      SEC_4: begin r_c = s3_t; g_c = s3_p; b_c = s3_v; end
      SEC_5: begin r_c = s3_v; g_c = s3_p; b_c = s3_q; end
      default: begin r_c = s3_v; g_c = s3_t; b_c = s3_p; end
    endcase
  end

  // Outputs hold the last converted pixel while no valid pixel arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r     <= '0;
      rgb_g     <= '0;
      rgb_b     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= s3_valid;
      if (s3_valid) begin
        rgb_r <= r_c;
        rgb_g <= g_c;
        rgb_b <= b_c;
      end
    end
  end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Scoreboard bench for hsv_to_rgb: stimulus pushes model results into a
// queue, a negedge monitor pops and compares on every valid_out.
module tb_hsv_to_rgb;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] hsv_h;
  logic [7:0] hsv_s;
  logic [7:0] hsv_v;
  logic       valid_in;
  logic [7:0] rgb_r;
  logic [7:0] rgb_g;
  logic [7:0] rgb_b;
  logic       valid_out;

  hsv_to_rgb dut (
    .clk       (clk),
    .rst       (rst),
    .hsv_h     (hsv_h),
    .hsv_s     (hsv_s),
    .hsv_v     (hsv_v),
    .valid_in  (valid_in),
    .rgb_r     (rgb_r),
    .rgb_g     (rgb_g),
    .rgb_b     (rgb_b),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int g;
    int b;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   npulse   = 0;
  int   last_r   = 0;
  int   last_g   = 0;
  int   last_b   = 0;
  int   rt_max_v_err = 0;
  logic rst_seen;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: floating-free integer HSV->RGB with the truncations of the
  // converter's definition, written with plain division.
  function automatic void model(input int h, input int s, input int v,
                                output int r, output int g, output int b);
    int hp;
    int sec;
    int f;
    int fr;
    int x;
    int p;
    int q;
    int t;
    hp  = (h >= 360) ? h - 360 : h;
    sec = hp / 60;
    f   = hp % 60;
    fr  = (f * 1092) / 256;
    x   = (v * s) / 256;
    p   = v - x;
    q   = v - (x * fr) / 256;
    t   = v - (x * (256 - fr)) / 256;
    case (sec)
      0:       begin r = v; g = t; b = p; end
      1:       begin r = q; g = v; b = p; end
      2:       begin r = p; g = v; b = t; end
      3:       begin r = p; g = q; b = v; end
      4:       begin r = t; g = p; b = v; end
      default: begin r = v; g = p; b = q; end
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int h, input int s, input int v,
                      input int r, input int g, input int b);
    exp_t e;
    e.r = r; e.g = g; e.b = b; e.cyc = cyc;
    sb.push_back(e);
    hsv_h    = 9'(h);
    hsv_s    = 8'(s);
    hsv_v    = 8'(v);
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic drive(input int h, input int s, input int v);
    int r;
    int g;
    int b;
    int mx;
    model(h, s, v, r, g, b);
    mx = (r > g) ? r : g;
    mx = (mx > b) ? mx : b;
    if (((mx > v) ? mx - v : v - mx) > rt_max_v_err)
      rt_max_v_err = (mx > v) ? mx - v : v - mx;
    push(h, s, v, r, g, b);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_seen === 1'b1) begin
      chk("reset_r", int'(rgb_r), 0);
      chk("reset_g", int'(rgb_g), 0);
      chk("reset_b", int'(rgb_b), 0);
      chk("reset_valid", int'(valid_out), 0);
      last_r = 0; last_g = 0; last_b = 0;
    end else if (valid_out === 1'b1) begin
      npulse++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rgb_r", int'(rgb_r), e.r);
        chk("rgb_g", int'(rgb_g), e.g);
        chk("rgb_b", int'(rgb_b), e.b);
        chk("latency", cyc - e.cyc, 4);
        last_r = e.r; last_g = e.g; last_b = e.b;
      end
    end else begin
      chk("hold_r", int'(rgb_r), last_r);
      chk("hold_g", int'(rgb_g), last_g);
      chk("hold_b", int'(rgb_b), last_b);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst      = 1'b1;
    valid_in = 1'b0;
    hsv_h    = '0;
    hsv_s    = '0;
    hsv_v    = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Directed vectors with hand-derived expectations.
    push(0,   255, 255, 255, 1,   1);
    idle(5);
    push(60,  255, 255, 255, 255, 1);
    push(120, 255, 255, 1,   255, 1);
    push(30,  255, 200, 200, 100, 1);
    push(270, 128, 100, 75,  50,  100);
    idle(6);

    // Grey sweep and hue wrap-around.
    for (int h = 0; h <= 360; h++) push(h, 0, 77, 77, 77, 77);
    drive(360, 200, 180);
    drive(0,   200, 180);
    drive(400, 150, 220);
    drive(40,  150, 220);
    drive(511, 255, 255);
    drive(100, 255, 0);
    idle(6);

    // Burst of 16, gap of 3, then 5 more.
    p0 = npulse;
    for (int i = 0; i < 16; i++) drive($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 255));
    idle(3);
    for (int i = 0; i < 5; i++) drive($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 255));
    idle(6);
    chk("burst_pulses", npulse - p0, 21);

    // Reset with three pixels in flight.
    p0 = npulse;
    for (int i = 0; i < 3; i++) drive(10 + 50 * i, 200, 200);
    rst = 1'b1;
    sb.delete();
    idle(1);
    rst = 1'b0;
    idle(6);
    chk("reset_flush_pulses", npulse - p0, 0);
    drive(200, 180, 160);
    idle(6);

    // Random stream with sporadic gaps.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      drive($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    idle(8);
    chk("drain_empty", sb.size(), 0);

    $display("round-trip stats: max |max(r,g,b)-V| = %0d", rt_max_v_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
